sram_bank_access_ctrl: RTL and testbench
========================================

Name: sram_bank_access_ctrl

Overview:
- Access sequencer and arbiter for one 2-port SRAM bank (decoder plus cell array) in the adiabatic datapath.
- Shares the bank between two requesters, granting one access per Bennett instruction cycle.
- Drives the decoder address bus inA, ReadEn and WriteEn in lock-step with the bennett_clock phase ramp clkp.
- Sits between the pipeline register-file logic and the SRAM decoder.

Parameters:
- PHASES, 10: width of clkp; one Bennett cycle = one full ramp of clkp[0]..clkp[PHASES-1].
- ADDR_W, 5: address width (32 words).
- ADDR_PHASE, 2: rising edge of clkp[ADDR_PHASE] = arbitration and address launch point.
- RD_ON_PHASE, 6: rising edge asserts ReadEn.
- RD_OFF_PHASE, 8: rising edge deasserts ReadEn.
- WR_ON_PHASE, 8: rising edge asserts WriteEn.
- WR_OFF_PHASE, 9: rising edge deasserts WriteEn.

Ports:
- clk  in  1  system clock; also drives bennett_clock.
- reset  in  1  synchronous, active-high reset.
- clkp  in  PHASES  Bennett phase levels from bennett_clock; sampled on clk.
- req  in  2  per-requester access request; level, held until ack.
- we  in  2  per-requester 1 = write, 0 = read; stable while req high.
- addr0  in  ADDR_W  requester 0 address.
- addr1  in  ADDR_W  requester 1 address.
- ack  out  2  one-clk completion pulse to the granted requester.
- gnt_id  out  1  index of the current/last granted requester.
- busy  out  1  high from grant until ack cycle inclusive.
- inA  out  ADDR_W  address to the decoder.
- ReadEn  out  1  decoder read enable.
- WriteEn  out  1  decoder write enable.

Behaviour:
- Edge detect: clkp_q registered each clk; rise[i] = clkp[i] & ~clkp_q[i]. On reset, clkp_q <= clkp, so no spurious edge after reset.
- Reset values: ack=0, gnt_id=0, busy=0, inA=0, ReadEn=0, WriteEn=0, state=IDLE, rr_ptr=0.
- FSM states:
  - IDLE: on rise[ADDR_PHASE] with req!=0, grant and go to ADDR. Otherwise stay in IDLE.
  - ADDR: read granted (we=0) goes to RD_WAIT; write goes to WR_WAIT. Both transitions are immediate.
  - RD_WAIT: on rise[RD_ON_PHASE], ReadEn<=1, go to RD_ACT.
  - RD_ACT: on rise[RD_OFF_PHASE], ReadEn<=0, go to DONE.
  - WR_WAIT: on rise[WR_ON_PHASE], WriteEn<=1, go to WR_ACT.
  - WR_ACT: on rise[WR_OFF_PHASE], WriteEn<=0, go to DONE.
  - DONE: ack[gnt_id]<=1 for exactly one clk, busy drops with it, return to IDLE.
- Grant (registered at the rise[ADDR_PHASE] clk):
  - If only one requester is active, it wins.
  - If both are active, requester rr_ptr wins.
  - gnt_id<=winner, inA<=winner's address, we latched, busy<=1, rr_ptr<=~winner.
- Address hold: inA holds its value after ack until the next grant; it never changes between grant and ack.
- ReadEn and WriteEn are never high simultaneously. Each is asserted for exactly one enable window per access.
- Missed window: a req that rises after rise[ADDR_PHASE] waits for the next Bennett cycle.
- Throughput: at most one access per Bennett cycle.
- Request after ack: req still high in the clk after ack counts as a new request in the next cycle.
- Dropped request: dropping req before ack is illegal; the access completes regardless.
- Reset mid-access: next clk, ReadEn=WriteEn=0, state=IDLE, no ack issued.
- Phase-parameter constraint: ADDR_PHASE < RD_ON_PHASE < RD_OFF_PHASE and ADDR_PHASE < WR_ON_PHASE < WR_OFF_PHASE, all < PHASES. Violation is a static $error at elaboration.

Optional Feature:
- Macro: SRAM_ACCESS_CTRL_PERF_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments in the DONE cycle of a read or write, respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single read: req=2'b01, we0=0, addr0=5'd1 → inA=1 at rise clkp[2]; ReadEn high from rise clkp[6] to rise clkp[8]; ack=2'b01 one clk later; WriteEn stays 0.
- Single write: req=2'b10, we1=1, addr1=5'd31 → inA=31; WriteEn high rise clkp[8] to rise clkp[9]; ack=2'b10; ReadEn stays 0.
- Contention: both req held, addr0=3, addr1=7, reads, for 4 Bennett cycles → grants 0,1,0,1; inA 3,7,3,7; exactly one ack per cycle.
- Late request: req0 raised after rise clkp[2] → no enable that cycle; granted at the next cycle's rise clkp[2].
- Reset mid-write: reset pulsed while WriteEn=1 → WriteEn=0 next clk, no ack, busy=0; a fresh req is then serviced normally.
- With SRAM_ACCESS_CTRL_PERF_EN: 3 reads plus 2 writes → rd_count=3, wr_count=2; preload near saturation → count holds at 16'hFFFF.

Source files
------------

// File: rtl/sram_bank_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bank_access_ctrl
//
// Purpose:
//   Access sequencer and arbiter for one 2-port SRAM bank (decoder plus cell
//   array) in the adiabatic datapath. Two requesters share the bank. At most
//   one access is granted per Bennett instruction cycle, i.e. per full ramp of
//   clkp[0]..clkp[PHASES-1]. The decoder address bus inA, ReadEn and WriteEn
//   are driven in lock-step with the phase ramp coming from bennett_clock.
//
// Ports:
//   clk        in   1       system clock (also drives bennett_clock)
//   reset      in   1       synchronous, active-high reset
//   clkp       in   PHASES  Bennett phase levels, sampled on clk
//   req        in   2       per-requester request level, held until ack
//   we         in   2       per-requester 1 = write, 0 = read
//   addr0      in   ADDR_W  requester 0 address
//   addr1      in   ADDR_W  requester 1 address
//   ack        out  2       one-clk completion pulse to the granted requester
//   gnt_id     out  1       index of the current/last granted requester
//   busy       out  1       high from grant until the ack cycle inclusive
//   inA        out  ADDR_W  address to the decoder
//   ReadEn     out  1       decoder read enable
//   WriteEn    out  1       decoder write enable
//
// Optional feature (macro SRAM_ACCESS_CTRL_PERF_EN):
//   rd_count   out  16      completed reads, saturating at 16'hFFFF
//   wr_count   out  16      completed writes, saturating at 16'hFFFF
//   With the macro undefined these ports and counters do not exist.
// -----------------------------------------------------------------------------
module sram_bank_access_ctrl #(
  parameter int PHASES       = 10,
  parameter int ADDR_W       = 5,
  parameter int ADDR_PHASE   = 2,
  parameter int RD_ON_PHASE  = 6,
  parameter int RD_OFF_PHASE = 8,
  parameter int WR_ON_PHASE  = 8,
  parameter int WR_OFF_PHASE = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkp,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        ack,
  output logic              gnt_id,
  output logic              busy,
  output logic [ADDR_W-1:0] inA,
  output logic              ReadEn,
  output logic              WriteEn
`ifdef SRAM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  // The enable windows only make sense if every event comes after the
  // address launch and in ramp order, all inside one Bennett cycle. A bad
  // parameter set is rejected while the design is being elaborated.
  if (!((ADDR_PHASE < RD_ON_PHASE) && (RD_ON_PHASE < RD_OFF_PHASE) &&
        (ADDR_PHASE < WR_ON_PHASE) && (WR_ON_PHASE < WR_OFF_PHASE) &&
        (RD_OFF_PHASE < PHASES) && (WR_OFF_PHASE < PHASES) &&
        (ADDR_PHASE >= 0))) begin : g_phaseOrderCheck
    $error("sram_bank_access_ctrl: phase parameters out of order");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACT  = 3'd3,
    WR_WAIT = 3'd4,
    WR_ACT  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_stateNxt;
  logic [PHASES-1:0]   r_clkpQ;
  logic [PHASES-1:0]   w_rise;
  logic [1:0]          r_ack;
  logic [1:0]          w_ackNxt;
  logic                r_gntId;
  logic                w_gntIdNxt;
  logic                r_busy;
  logic                w_busyNxt;
  logic [ADDR_W-1:0]   r_inA;
  logic [ADDR_W-1:0]   w_inANxt;
  logic                r_readEn;
  logic                w_readEnNxt;
  logic                r_writeEn;
  logic                w_writeEnNxt;
  logic                r_rrPtr;
  logic                w_rrPtrNxt;
  logic                r_weLat;
  logic                w_weLatNxt;
  logic                w_winner;

  // A phase "rises" in the clk where its level is newly seen high compared to
  // the previous clk's sample. Every sequencing decision keys off these
  // single-clk rise pulses rather than off the phase levels.
  assign w_rise = clkp & ~r_clkpQ;

  // Arbitration: a lone requester always wins; when both are asking, the
  // round-robin pointer breaks the tie so neither side can starve.
  assign w_winner = (req == 2'b11) ? r_rrPtr : req[1];

  // Next-state and next-output logic. Every register holds by default and
  // ack defaults low so it can only ever be a single-clk pulse. busy is
  // cleared on the IDLE clk that follows DONE, which is exactly the clk in
  // which ack is visible, so busy covers the ack cycle and drops with it.
  always_comb begin
    w_stateNxt   = r_state;
    w_ackNxt     = 2'b00;
    w_gntIdNxt   = r_gntId;
    w_busyNxt    = r_busy;
    w_inANxt     = r_inA;
    w_readEnNxt  = r_readEn;
    w_writeEnNxt = r_writeEn;
    w_rrPtrNxt   = r_rrPtr;
    w_weLatNxt   = r_weLat;

    case (r_state)
      IDLE: begin
        w_busyNxt = 1'b0;
        if (w_rise[ADDR_PHASE] && (req != 2'b00)) begin
          w_gntIdNxt = w_winner;
          w_inANxt   = w_winner ? addr1 : addr0;
          w_weLatNxt = we[w_winner];
          w_busyNxt  = 1'b1;
          w_rrPtrNxt = ~w_winner;
          w_stateNxt = ADDR;
        end
      end

      ADDR: begin
        w_stateNxt = r_weLat ? WR_WAIT : RD_WAIT;
      end

      RD_WAIT: begin
        if (w_rise[RD_ON_PHASE]) begin
          w_readEnNxt = 1'b1;
          w_stateNxt  = RD_ACT;
        end
      end

      RD_ACT: begin
        if (w_rise[RD_OFF_PHASE]) begin
          w_readEnNxt = 1'b0;
          w_stateNxt  = DONE;
        end
      end

      WR_WAIT: begin
        if (w_rise[WR_ON_PHASE]) begin
          w_writeEnNxt = 1'b1;
          w_stateNxt   = WR_ACT;
        end
      end

      WR_ACT: begin
        if (w_rise[WR_OFF_PHASE]) begin
          w_writeEnNxt = 1'b0;
          w_stateNxt   = DONE;
        end
      end

      DONE: begin
        w_ackNxt   = r_gntId ? 2'b10 : 2'b01;
        w_stateNxt = IDLE;
      end

      default: begin
        w_readEnNxt  = 1'b0;
        w_writeEnNxt = 1'b0;
        w_stateNxt   = IDLE;
      end
    endcase
  end

  // State and output registers. On reset the phase history is loaded with the
  // live clkp value instead of zero, so a phase that is already high while
  // reset is applied is not mistaken for a fresh rise afterwards. Reset also
  // kills any access in flight: the enables drop and no ack is ever issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clkpQ   <= clkp;
      r_state   <= IDLE;
      r_ack     <= 2'b00;
      r_gntId   <= 1'b0;
      r_busy    <= 1'b0;
      r_inA     <= '0;
      r_readEn  <= 1'b0;
      r_writeEn <= 1'b0;
      r_rrPtr   <= 1'b0;
      r_weLat   <= 1'b0;
    end else begin
      r_clkpQ   <= clkp;
      r_state   <= w_stateNxt;
      r_ack     <= w_ackNxt;
      r_gntId   <= w_gntIdNxt;
      r_busy    <= w_busyNxt;
      r_inA     <= w_inANxt;
      r_readEn  <= w_readEnNxt;
      r_writeEn <= w_writeEnNxt;
      r_rrPtr   <= w_rrPtrNxt;
      r_weLat   <= w_weLatNxt;
    end
  end

  assign ack     = r_ack;
  assign gnt_id  = r_gntId;
  assign busy    = r_busy;
  assign inA     = r_inA;
  assign ReadEn  = r_readEn;
  assign WriteEn = r_writeEn;

`ifdef SRAM_ACCESS_CTRL_PERF_EN
  logic [15:0] r_rdCount;
  logic [15:0] r_wrCount;

  // Completed-access counters. They step in the DONE clk, so the new count
  // becomes visible together with ack, and they stick at all-ones instead of
  // wrapping so a long run never reports a misleadingly small number.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdCount <= 16'h0000;
      r_wrCount <= 16'h0000;
    end else if (r_state == DONE) begin
      if (!r_weLat && (r_rdCount != 16'hFFFF)) begin
        r_rdCount <= r_rdCount + 16'h0001;
      end
      if (r_weLat && (r_wrCount != 16'hFFFF)) begin
        r_wrCount <= r_wrCount + 16'h0001;
      end
    end
  end

  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;
`endif

endmodule

// File: tb/tb_sram_bank_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_bank_access_ctrl
//
// Self-checking bench for sram_bank_access_ctrl. The Bennett ramp is a
// 24-step schedule in which phase i is high for steps 2i..2i+3, so phase i
// rises at step 2i. The reference model works purely from that schedule:
// an access is granted at step 4 (ADDR_PHASE), a read enable is expected for
// steps 12..15, a write enable for steps 16..17, and ack one step after the
// enable window closes. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_sram_bank_access_ctrl;

  localparam int PHASES = 10;
  localparam int ADDR_W = 5;
  localparam int PERIOD = 24;
  localparam int GRANT_STEP = 4;
  localparam int RD_FIRST = 12;
  localparam int RD_LAST = 15;
  localparam int WR_FIRST = 16;
  localparam int WR_LAST = 17;
  localparam int RD_ACK_STEP = 17;
  localparam int WR_ACK_STEP = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic [PHASES-1:0] clkp;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        ack;
  logic              gnt_id;
  logic              busy;
  logic [ADDR_W-1:0] inA;
  logic              ReadEn;
  logic              WriteEn;
`ifdef SRAM_ACCESS_CTRL_PERF_EN
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
`endif

  int errorCount = 0;
  int checkCount = 0;
  int step = 0;

  // Reference model state
  bit                mActive;
  bit                mWr;
  bit                mWin;
  bit                mRr;
  bit                mLastWin;
  logic [ADDR_W-1:0] mAddr;
  int                mRdCount;
  int                mWrCount;
  bit                holdAfterAck [2];

  always #5 clk = ~clk;

  sram_bank_access_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .clkp    (clkp),
    .req     (req),
    .we      (we),
    .addr0   (addr0),
    .addr1   (addr1),
    .ack     (ack),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .inA     (inA),
    .ReadEn  (ReadEn),
    .WriteEn (WriteEn)
`ifdef SRAM_ACCESS_CTRL_PERF_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h (step %0d, t=%0t)",
               tag, observed, expected, step, $time);
    end
  endtask

  // Phase levels for one step of the Bennett ramp schedule.
  function automatic logic [PHASES-1:0] phaseVec(input int s);
    logic [PHASES-1:0] v;
    for (int i = 0; i < PHASES; i++) begin
      v[i] = (s >= 2 * i) && (s < 2 * i + 4);
    end
    return v;
  endfunction

  // Drives one clk worth of inputs, advances the model using the same inputs
  // the DUT sampled, and compares every output one time unit after the edge.
  task automatic applyStimulus(input bit rst);
    logic [1:0] eAck;
    bit         eRe;
    bit         eWe;
    bit         eBusy;
    int         ackStep;

    reset = rst;
    clkp  = phaseVec(step);
    @(posedge clk);
    #1;

    eAck  = 2'b00;
    eRe   = 1'b0;
    eWe   = 1'b0;
    eBusy = 1'b0;
    if (rst) begin
      mActive  = 1'b0;
      mRr      = 1'b0;
      mLastWin = 1'b0;
      mAddr    = '0;
      mRdCount = 0;
      mWrCount = 0;
    end else begin
      if (step == GRANT_STEP && !mActive && req != 2'b00) begin
        if (req == 2'b11) mWin = mRr;
        else mWin = req[1];
        mRr      = !mWin;
        mLastWin = mWin;
        mAddr    = mWin ? addr1 : addr0;
        mWr      = we[mWin];
        mActive  = 1'b1;
      end
      ackStep = mWr ? WR_ACK_STEP : RD_ACK_STEP;
      eRe   = mActive && !mWr && step >= RD_FIRST && step <= RD_LAST;
      eWe   = mActive && mWr && step >= WR_FIRST && step <= WR_LAST;
      eBusy = mActive && step >= GRANT_STEP && step <= ackStep;
      if (mActive && step == ackStep) begin
        eAck = mLastWin ? 2'b10 : 2'b01;
        if (mWr) mWrCount = (mWrCount < 65535) ? mWrCount + 1 : 65535;
        else mRdCount = (mRdCount < 65535) ? mRdCount + 1 : 65535;
        mActive = 1'b0;
      end
    end

    checkOutput("ack", 32'(ack), 32'(eAck));
    checkOutput("gnt_id", 32'(gnt_id), 32'(mLastWin));
    checkOutput("busy", 32'(busy), 32'(eBusy));
    checkOutput("inA", 32'(inA), 32'(mAddr));
    checkOutput("ReadEn", 32'(ReadEn), 32'(eRe));
    checkOutput("WriteEn", 32'(WriteEn), 32'(eWe));
    checkOutput("enable_overlap", 32'(ReadEn & WriteEn), 32'd0);
`ifdef SRAM_ACCESS_CTRL_PERF_EN
    checkOutput("rd_count", 32'(rd_count), 32'(mRdCount));
    checkOutput("wr_count", 32'(wr_count), 32'(mWrCount));
`endif

    for (int k = 0; k < 2; k++) begin
      if (eAck[k] && !holdAfterAck[k]) req[k] = 1'b0;
    end
    step = (step + 1) % PERIOD;
  endtask

  task automatic runUntil(input int target);
    do applyStimulus(1'b0); while (step != target);
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n * PERIOD; c++) applyStimulus(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    clkp  = '0;
    req   = 2'b00;
    we    = 2'b00;
    addr0 = '0;
    addr1 = '0;
    holdAfterAck[0] = 1'b0;
    holdAfterAck[1] = 1'b0;

    // Reset values
    repeat (3) applyStimulus(1'b1);
    runUntil(0);

    // Single read from requester 0
    we = 2'b00; addr0 = 5'd1; req = 2'b01;
    runCycles(1);

    // Single write from requester 1
    we = 2'b10; addr1 = 5'd31; req = 2'b10;
    runCycles(1);

    // Contention: both reading, alternating grants 0,1,0,1
    we = 2'b00; addr0 = 5'd3; addr1 = 5'd7; req = 2'b11;
    holdAfterAck[0] = 1'b1; holdAfterAck[1] = 1'b1;
    runCycles(2);
    holdAfterAck[0] = 1'b0;
    runCycles(1);
    holdAfterAck[1] = 1'b0;
    runCycles(1);

    // Late request: raised after the address launch, served next cycle
    runUntil(6);
    we = 2'b00; addr0 = 5'd9; req = 2'b01;
    runCycles(2);
    runUntil(0);

    // Reset while WriteEn is high, then the still-pending request is served
    we = 2'b10; addr1 = 5'd12; req = 2'b10;
    runUntil(17);
    applyStimulus(1'b1);
    runUntil(0);
    runCycles(1);

    // Random traffic
    for (int n = 0; n < 40 * PERIOD; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (req[k] == 1'b0 && $urandom_range(0, 7) == 0) begin
          we[k] = 1'($urandom_range(0, 1));
          if (k == 0) addr0 = 5'($urandom_range(0, 31));
          else addr1 = 5'($urandom_range(0, 31));
          holdAfterAck[k] = 1'($urandom_range(0, 1));
          req[k] = 1'b1;
        end
      end
      applyStimulus($urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
